// File: rtl/dds_serial_loader_if.sv
// ---------------------------------------------------------------------------
// dds_serial_loader_if
// Load-request bundle between the frequency-select logic and the DDS serial
// loader.
//
// Handshake: the master raises req with ftw/ctrl valid. The loader samples
// req only on its internal tick and only while idle, which is while busy=0.
// Accepting the request captures ftw/ctrl and raises busy. A req that arrives
// while busy=1 is dropped and is not queued. When the frame finishes, the
// loader pulses done for one clk and drops busy in that same cycle.
//
// Signals (all driven/observed in the clk domain of the loader):
//   req   master->slave  load request
//   ftw   master->slave  tuning word, FTW_W bits
//   ctrl  master->slave  control byte, CTRL_W bits
//   busy  slave->master  loader occupied (init or frame in flight)
//   done  slave->master  one-clk pulse at end of a load
// ---------------------------------------------------------------------------
interface dds_serial_loader_if #(
  parameter int FTW_W  = 32,
  parameter int CTRL_W = 8
);
  logic              req;
  logic [FTW_W-1:0]  ftw;
  logic [CTRL_W-1:0] ctrl;
  logic              busy;
  logic              done;

  modport master (output req, ftw, ctrl, input  busy, done);
  modport slave  (input  req, ftw, ctrl, output busy, done);
endinterface

// File: rtl/dds_serial_loader.sv
// ---------------------------------------------------------------------------
// dds_serial_loader
// Serial-load controller for AD9850-class DDS devices. After reset it runs
// the device reset / serial-mode-entry sequence. It then shifts
// {ctrl,ftw} out LSB-first on a divided W_CLK and ends each frame with an
// FQ_UD strobe.
//
// Optional feature: define AUTO_UPDATE_EN to add a shadow of the last loaded
// {ctrl,ftw}. While idle, any difference from the shadow starts a load
// exactly as req does.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport: req/ftw/ctrl in, busy/done out
//   W_CLK    out  DDS word clock
//   FQ_UD    out  DDS frequency update strobe
//   DATA     out  DDS serial data (D7)
//   RESET    out  DDS master reset, active high
//   o_state  out  current FSM state (debug)
// ---------------------------------------------------------------------------
module dds_serial_loader #(
  parameter int FTW_W     = 32,
  parameter int CTRL_W    = 8,
  parameter int CLK_DIV   = 2,
  parameter int RST_TICKS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  dds_serial_loader_if.slave  bus,
  output logic                W_CLK,
  output logic                FQ_UD,
  output logic                DATA,
  output logic                RESET,
  output logic [2:0]          o_state
);

  localparam int FRAME_W = FTW_W + CTRL_W;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RCNT_W  = $clog2(RST_TICKS + 1);
  localparam int BIT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

  typedef enum logic [2:0] {
    S_INIT_RST  = 3'd0,
    S_INIT_WCLK = 3'd1,
    S_INIT_FQ   = 3'd2,
    S_IDLE      = 3'd3,
    S_SETUP     = 3'd4,
    S_HIGH      = 3'd5,
    S_FQ        = 3'd6,
    S_FQ_LOW    = 3'd7
  } state_t;

  state_t             r_state, w_state_next;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [RCNT_W-1:0]  r_tick_cnt, w_tick_cnt_next;
  logic [BIT_W-1:0]   r_bit_cnt, w_bit_cnt_next;
  logic [FRAME_W-1:0] r_sreg, w_sreg_next;
  logic               r_w_clk, r_fq_ud, r_data, r_reset, r_busy, r_done;
  logic               w_w_clk, w_fq_ud, w_data, w_reset, w_busy;
  logic               w_tick, w_start, w_accept;
  logic [FRAME_W-1:0] w_frame_in;

  assign w_frame_in = {bus.ctrl, bus.ftw};

  // Single-cycle enable; with CLK_DIV=1 the counter stays at 0 and the tick
  // is permanently high.
  assign w_tick = (r_div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_div_cnt <= '0;
    else if (w_tick) r_div_cnt <= '0;
    else             r_div_cnt <= r_div_cnt + DIV_W'(1);
  end

`ifdef AUTO_UPDATE_EN
  logic [FRAME_W-1:0] r_shadow;
  assign w_start = bus.req || (w_frame_in != r_shadow);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_shadow <= '0;
    else if (w_accept) r_shadow <= w_frame_in;
  end
`else
  assign w_start = bus.req;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_INIT_RST;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_sreg     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_tick_cnt <= w_tick_cnt_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_sreg     <= w_sreg_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_tick_cnt_next = r_tick_cnt;
    w_bit_cnt_next  = r_bit_cnt;
    w_sreg_next     = r_sreg;
    w_accept        = 1'b0;
    if (w_tick) begin
      unique case (r_state)
        // The first tick after reset release raises RESET. The compare
        // against RST_TICKS (not RST_TICKS-1) then keeps it high for
        // RST_TICKS full ticks.
        S_INIT_RST: begin
          if (r_tick_cnt == RCNT_W'(RST_TICKS)) begin
            w_state_next    = S_INIT_WCLK;
            w_tick_cnt_next = '0;
          end else begin
            w_tick_cnt_next = r_tick_cnt + RCNT_W'(1);
          end
        end
        S_INIT_WCLK: w_state_next = S_INIT_FQ;
        S_INIT_FQ:   w_state_next = S_IDLE;
        S_IDLE: begin
          if (w_start) begin
            w_accept       = 1'b1;
            w_sreg_next    = w_frame_in;
            w_bit_cnt_next = '0;
            w_state_next   = S_SETUP;
          end
        end
        S_SETUP: w_state_next = S_HIGH;
        S_HIGH: begin
          w_sreg_next    = r_sreg >> 1;
          w_bit_cnt_next = r_bit_cnt + BIT_W'(1);
          w_state_next   = (r_bit_cnt == BIT_W'(FRAME_W - 1)) ? S_FQ : S_SETUP;
        end
        S_FQ:     w_state_next = S_FQ_LOW;
        S_FQ_LOW: w_state_next = S_IDLE;
        default:  w_state_next = S_INIT_RST;
      endcase
    end
    // Pin values for the state being entered. They are registered on the
    // same tick, so each pin phase is exactly one tick long and the pins are
    // glitch-free.
    w_reset = (w_state_next == S_INIT_RST);
    w_w_clk = (w_state_next == S_INIT_WCLK) || (w_state_next == S_HIGH);
    w_fq_ud = (w_state_next == S_INIT_FQ)   || (w_state_next == S_FQ);
    w_data  = ((w_state_next == S_SETUP) || (w_state_next == S_HIGH)) ? w_sreg_next[0] : 1'b0;
    w_busy  = (w_state_next != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_w_clk <= 1'b0;
      r_fq_ud <= 1'b0;
      r_data  <= 1'b0;
      r_reset <= 1'b0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_tick && (r_state == S_FQ_LOW);
      if (w_tick) begin
        r_w_clk <= w_w_clk;
        r_fq_ud <= w_fq_ud;
        r_data  <= w_data;
        r_reset <= w_reset;
        r_busy  <= w_busy;
      end
    end
  end

  assign W_CLK    = r_w_clk;
  assign FQ_UD    = r_fq_ud;
  assign DATA     = r_data;
  assign RESET    = r_reset;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign o_state  = r_state;

endmodule

// File: tb/tb_dds_serial_loader.sv
// ---------------------------------------------------------------------------
// tb_dds_serial_loader
// Directed bench for dds_serial_loader. u_dut0 uses the default divider
// (CLK_DIV=2) and u_dut1 uses CLK_DIV=1. A monitor per DUT reassembles the
// serial frame at each W_CLK rise. It pops the expected frame from a queue
// at FQ_UD rise and compares the two.
// ---------------------------------------------------------------------------
module tb_dds_serial_loader;

  localparam logic [31:0] FTW_A = 32'h28F5C28F;
  localparam logic [31:0] FTW_B = 32'h147AE148;
  localparam logic [31:0] FTW_C = 32'h12345678;

  logic clk, rst_n, rst1_n;
  logic W_CLK0, FQ_UD0, DATA0, RESET0;
  logic W_CLK1, FQ_UD1, DATA1, RESET1;
  logic [2:0] st0, st1;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  dds_serial_loader_if #(.FTW_W(32), .CTRL_W(8)) bus0 ();
  dds_serial_loader_if #(.FTW_W(32), .CTRL_W(8)) bus1 ();

  dds_serial_loader #(.FTW_W(32), .CTRL_W(8), .CLK_DIV(2), .RST_TICKS(4)) u_dut0 (
    .clk(clk), .reset_n(rst_n), .bus(bus0),
    .W_CLK(W_CLK0), .FQ_UD(FQ_UD0), .DATA(DATA0), .RESET(RESET0), .o_state(st0)
  );

  dds_serial_loader #(.FTW_W(32), .CTRL_W(8), .CLK_DIV(1), .RST_TICKS(4)) u_dut1 (
    .clk(clk), .reset_n(rst1_n), .bus(bus1),
    .W_CLK(W_CLK1), .FQ_UD(FQ_UD1), .DATA(DATA1), .RESET(RESET1), .o_state(st1)
  );

  // ---- clock / reset ----
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---- scoreboard / monitor, DUT0 ----
  logic [39:0] exp0_q[$];
  logic [39:0] asm0;
  int nbits0, done_cnt0, acc_cyc0, lat0;
  bit live0, ovl0;
  logic wclk_d0, fq_d0, busy_d0, done_d0;

  always @(negedge clk) begin
    if (!rst_n) begin
      live0 = 0; nbits0 = 0; asm0 = '0;
    end else begin
      if (bus0.busy === 1'b0) live0 = 1;
      if (W_CLK0 === 1'b1 && FQ_UD0 === 1'b1) ovl0 = 1;
      if (live0) begin
        if (W_CLK0 === 1'b1 && wclk_d0 === 1'b0) begin
          asm0 = {DATA0, asm0[39:1]};
          nbits0++;
        end
        if (FQ_UD0 === 1'b1 && fq_d0 === 1'b0) begin
          check("frame0_bits", nbits0, 40);
          vectors++;
          assert (exp0_q.size() > 0) else begin
            errors++;
            $error("FAIL frame0_pending observed=none expected=queued frame");
          end
          if (exp0_q.size() > 0) check("frame0_data", asm0, exp0_q.pop_front());
          nbits0 = 0;
        end
        if (bus0.busy === 1'b1 && busy_d0 === 1'b0) acc_cyc0 = cyc;
        if (bus0.done === 1'b1 && done_d0 === 1'b0) begin
          done_cnt0++;
          lat0 = cyc - acc_cyc0;
        end
      end
    end
    wclk_d0 = W_CLK0; fq_d0 = FQ_UD0; busy_d0 = bus0.busy; done_d0 = bus0.done;
  end

  // ---- scoreboard / monitor, DUT1 ----
  logic [39:0] exp1_q[$];
  logic [39:0] asm1;
  int nbits1, done_cnt1, acc_cyc1, lat1, nfr1, low1;
  bit live1, ovl1;
  logic wclk_d1, fq_d1, busy_d1, done_d1;

  always @(negedge clk) begin
    if (!rst1_n) begin
      live1 = 0; nbits1 = 0; asm1 = '0; low1 = 0;
    end else begin
      if (bus1.busy === 1'b0) live1 = 1;
      if (W_CLK1 === 1'b1 && FQ_UD1 === 1'b1) ovl1 = 1;
      if (live1) begin
        if (bus1.busy === 1'b0) low1++;
        if (W_CLK1 === 1'b1 && wclk_d1 === 1'b0) begin
          asm1 = {DATA1, asm1[39:1]};
          nbits1++;
        end
        if (FQ_UD1 === 1'b1 && fq_d1 === 1'b0) begin
          check("frame1_bits", nbits1, 40);
          check("frame1_bit34", asm1[34], 1'b1);
          vectors++;
          assert (exp1_q.size() > 0) else begin
            errors++;
            $error("FAIL frame1_pending observed=none expected=queued frame");
          end
          if (exp1_q.size() > 0) check("frame1_data", asm1, exp1_q.pop_front());
          nbits1 = 0;
          nfr1++;
        end
        if (bus1.busy === 1'b1 && busy_d1 === 1'b0) begin
          acc_cyc1 = cyc;
          if (nfr1 > 0) check("frame1_idle_gap_clks", low1, 1);
          low1 = 0;
        end
        if (bus1.done === 1'b1 && done_d1 === 1'b0) begin
          done_cnt1++;
          lat1 = cyc - acc_cyc1;
        end
      end
    end
    wclk_d1 = W_CLK1; fq_d1 = FQ_UD1; busy_d1 = bus1.busy; done_d1 = bus1.done;
  end

  // ---- driver tasks ----
  task automatic init_check0(input string tag);
    int n, fq_pre;
    n = 0; fq_pre = 0;
    while (RESET0 !== 1'b1 && n < 40) begin
      if (FQ_UD0 === 1'b1) fq_pre++;
      @(negedge clk); n++;
    end
    check({tag, "_fq_before_init"}, fq_pre, 0);
    n = 0;
    while (RESET0 === 1'b1 && n < 50) begin @(negedge clk); n++; end
    check({tag, "_reset_high_clks"}, n, 8);
    n = 0;
    while (W_CLK0 === 1'b1 && n < 50) begin @(negedge clk); n++; end
    check({tag, "_wclk_high_clks"}, n, 2);
    n = 0;
    while (FQ_UD0 === 1'b1 && n < 50) begin @(negedge clk); n++; end
    check({tag, "_fqud_high_clks"}, n, 2);
    check({tag, "_idle_busy"}, bus0.busy, 1'b0);
    check({tag, "_idle_state"}, st0, 3'd3);
    check({tag, "_idle_pins"}, {W_CLK0, FQ_UD0, DATA0, RESET0, bus0.done}, 5'b0);
  endtask

  task automatic start_load0(input logic [31:0] ftw, input logic [7:0] ctrl);
    int n;
    @(negedge clk);
    bus0.ftw = ftw; bus0.ctrl = ctrl; bus0.req = 1'b1;
    exp0_q.push_back({ctrl, ftw});
    n = 0;
    while (bus0.busy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    bus0.req = 1'b0;
  endtask

  task automatic wait_done0(input string tag);
    int n;
    n = 0;
    while (bus0.done !== 1'b1 && n < 600) begin @(negedge clk); n++; end
    check({tag, "_done_seen"}, bus0.done, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  // ---- directed sequence ----
  initial begin
    int dc, n;
    rst_n = 1'b0; rst1_n = 1'b0;
    bus0.req = 1'b0; bus0.ftw = '0; bus0.ctrl = '0;
    bus1.req = 1'b0; bus1.ftw = '0; bus1.ctrl = '0;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_pins", {W_CLK0, FQ_UD0, DATA0, RESET0, bus0.done}, 5'b0);
    check("rst_busy", bus0.busy, 1'b1);
    check("rst_state", st0, 3'd0);
    rst_n = 1'b1;
    init_check0("init");

    // single load, latency
    dc = done_cnt0;
    start_load0(FTW_A, 8'h00);
    wait_done0("t2");
    check("t2_latency_clks", lat0, 164);
    check("t2_done_count", done_cnt0, dc + 1);
    check("t2_queue_empty", exp0_q.size(), 0);
    check("t2_idle_pins", {bus0.busy, W_CLK0, FQ_UD0, DATA0, RESET0}, 5'b0);

    // req and new ftw mid-frame are ignored
    dc = done_cnt0;
    start_load0(FTW_A, 8'h00);
    repeat (30) @(negedge clk);
    bus0.ftw = FTW_B; bus0.req = 1'b1;
    repeat (4) @(negedge clk);
    bus0.req = 1'b0; bus0.ftw = FTW_A;
    wait_done0("t3");
    repeat (300) @(negedge clk);
    check("t3_done_count", done_cnt0, dc + 1);
    check("t3_queue_empty", exp0_q.size(), 0);

    // reset mid-frame at bit 17
    dc = done_cnt0;
    @(negedge clk);
    bus0.ftw = FTW_A; bus0.ctrl = 8'h00; bus0.req = 1'b1;
    n = 0;
    while (bus0.busy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    bus0.req = 1'b0;
    n = 0;
    while (nbits0 < 17 && n < 200) begin @(negedge clk); n++; end
    check("t4_reached_bit17", nbits0 >= 17, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t4_abort_pins", {W_CLK0, FQ_UD0, DATA0, RESET0, bus0.done}, 5'b0);
    check("t4_abort_busy", bus0.busy, 1'b1);
    bus0.ftw = '0; bus0.ctrl = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    init_check0("reinit");
    check("t4_no_partial_done", done_cnt0, dc);
    check("t4_queue_empty", exp0_q.size(), 0);
    start_load0(FTW_B, 8'hA5);
    wait_done0("t4b");
    check("t4b_done_count", done_cnt0, dc + 1);
    check("t4b_queue_empty", exp0_q.size(), 0);

`ifdef AUTO_UPDATE_EN
    // automatic reload on input change
    dc = done_cnt0;
    @(negedge clk);
    exp0_q.push_back({8'h00, FTW_A});
    bus0.ftw = FTW_A; bus0.ctrl = 8'h00;
    wait_done0("t6a");
    @(negedge clk);
    exp0_q.push_back({8'h00, FTW_B});
    bus0.ftw = FTW_B;
    wait_done0("t6b");
    repeat (400) @(negedge clk);
    check("t6_done_count", done_cnt0, dc + 2);
    check("t6_queue_empty", exp0_q.size(), 0);
`endif

    // CLK_DIV=1, back-to-back with req held
    rst1_n = 1'b1;
    n = 0;
    while (bus1.busy !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    check("t5_init_done", bus1.busy, 1'b0);
    bus1.ftw = FTW_C; bus1.ctrl = 8'h04; bus1.req = 1'b1;
    repeat (3) exp1_q.push_back({8'h04, FTW_C});
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (bus1.done !== 1'b1 && n < 300);
      check("t5_done_seen", bus1.done, 1'b1);
    end
    bus1.req = 1'b0;
    repeat (200) @(negedge clk);
    check("t5_done_count", done_cnt1, 3);
    check("t5_frames", nfr1, 3);
    check("t5_latency_clks", lat1, 82);
    check("t5_queue_empty", exp1_q.size(), 0);

    check("dut0_wclk_fqud_overlap", ovl0, 1'b0);
    check("dut1_wclk_fqud_overlap", ovl1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
